lcd_timing_driver: RTL
======================

Name: lcd_timing_driver

Overview:
- Drives the RGB LCD panel with sync timing and the pixel coordinate stream.
- Pixel generators (the character/measurement overlay blocks) consume pixel_xpos/pixel_ypos and return registered pixel_data one lcd_pclk later.
- Coordinates are issued one cycle ahead of lcd_de, so a registered pixel_data lands exactly on the active pixel.
- Sits between the overlay mux and the panel pins.

Parameters:
H_SYNC, 128, hsync pulse width (pclk)
H_BACK, 88, horizontal back porch
H_DISP, 800, active pixels per line
H_TOTAL, 1056, total pclk per line (H_SYNC+H_BACK+H_DISP+front porch 40)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
V_DISP, 480, active lines
V_TOTAL, 525, total lines per frame (front porch 10)

Ports:
lcd_pclk  in  1  pixel clock, sole clock
sys_rst_n  in  1  asynchronous active-low reset
pixel_data  in  24  RGB888 from overlay, registered by producer one cycle after coordinates
pixel_xpos  out  11  column of pixel being requested; 0 when not requesting
pixel_ypos  out  11  row of pixel being requested; 0 when not requesting
data_req  out  1  high while coordinates are valid
lcd_hs  out  1  horizontal sync, active low
lcd_vs  out  1  vertical sync, active low
lcd_de  out  1  data enable
lcd_rgb  out  24  pixel bus to panel
lcd_bl  out  1  backlight enable
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the h_cnt wrap, counts 0..V_TOTAL-1, and wraps to 0.
  - Both reset to 0.
- Derived constants: H_START = H_SYNC+H_BACK = 216; V_START = V_SYNC+V_BACK = 35.
- data_req is combinational from the counters.
  - High when h_cnt is in [H_START-1, H_START+H_DISP-1) and v_cnt is in [V_START, V_START+V_DISP).
- Coordinates are combinational.
  - pixel_xpos = h_cnt-(H_START-1) and pixel_ypos = v_cnt-V_START when data_req is high.
  - Both are 0 otherwise.
  - Range is xpos 0..799, ypos 0..479.
- Registered outputs (1-cycle latency from counters):
  - lcd_de = data_req of the previous cycle.
  - lcd_hs = !(h_cnt < H_SYNC), previous cycle.
  - lcd_vs = !(v_cnt < V_SYNC), previous cycle.
  - All sync/DE outputs therefore share one alignment.
- lcd_rgb = lcd_de ? pixel_data : 24'h0 (combinational). Blanking is forced black regardless of pixel_data.
- lcd_bl is a register: 0 in reset, 1 from the first clock after reset release.
- frame_done is registered: it pulses for one cycle, in the cycle after h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
- Reset values: lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_bl=0, frame_done=0, counters 0. Hence data_req=0, pixel_xpos=0, pixel_ypos=0, lcd_rgb=0.
- Reset mid-line or mid-frame: all outputs return immediately (asynchronously) to reset values. After release, timing restarts at h_cnt=0, v_cnt=0; no partial line is completed.
- Line wrap: the last data_req of a line is at h_cnt=H_START+H_DISP-2, and its lcd_de falls one cycle later. No data_req or de during porches or sync.
- Frame wrap: v_cnt wraps to 0 on the same edge as the h_cnt wrap; vsync asserts from the next line 0.
- Widths:
  - Counters are 11 bits; parameters must satisfy H_TOTAL,V_TOTAL ≤ 2047.
  - Subtraction is done only under data_req, so no underflow is visible.

Decomposition:
- Package lcd_timing_pkg:
  - timing constants for the 800x480 panel plus H_START/V_START;
  - RGB888 colour constants (WHITE, BLACK);
  - COORD_W=11.
- One sub-module is natural: lcd_sync_cnt.
  - Contains the h/v counter pair with wrap, exposing h_cnt, v_cnt and a line_end strobe.
  - The top handles the request window, registered syncs/DE and the RGB gating.

Test Plan:
- Reset release, count cycles -> first data_req at cycle index 35*1056+215 = 37175 with xpos=0, ypos=0; lcd_de first high at 37176.
- Within active line 0 -> data_req is high for exactly 800 consecutive cycles; xpos increments 0..799 and ypos=0 throughout; lcd_de is high for 800 cycles starting one cycle after data_req.
- Sync widths -> lcd_hs low for exactly 128 cycles per 1056-cycle line; lcd_vs low for exactly 2*1056 = 2112 cycles per frame; frame_done pulses every 554400 cycles.
- Loopback stub registering pixel_data = {xpos[7:0], ypos[7:0], 8'hA5} -> on every lcd_de cycle lcd_rgb equals the stub value for the coordinate issued one cycle earlier; lcd_rgb=0 whenever lcd_de=0 even with pixel_data=24'hFFFFFF.
- Assert sys_rst_n low at h_cnt=500 of active line 100 -> outputs immediately lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, lcd_bl=0; after release the next data_req again occurs 37175 cycles later.
- Reduced parameters (H_TOTAL=20, H_SYNC=2, H_BACK=3, H_DISP=10, V_TOTAL=6, V_SYNC=1, V_BACK=1, V_DISP=3) -> data_req at h_cnt 4..13 on v_cnt 2..4 only; frame_done every 120 cycles.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Purpose : shared timing constants, coordinate/colour types for the 800x480 RGB panel path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package lcd_timing_pkg;

   localparam int COORD_W = 11;
   localparam int RGB_W   = 24;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [RGB_W-1:0]   rgb_t;

   // 800x480 panel timing, in pclk (horizontal) and lines (vertical).
   // Counters are COORD_W bits, so both totals must stay at or below 2047.
   localparam int LCD_H_SYNC  = 128;
   localparam int LCD_H_BACK  = 88;
   localparam int LCD_H_DISP  = 800;
   localparam int LCD_H_TOTAL = 1056;
   localparam int LCD_V_SYNC  = 2;
   localparam int LCD_V_BACK  = 33;
   localparam int LCD_V_DISP  = 480;
   localparam int LCD_V_TOTAL = 525;

   // First active column/row, counted from the start of the sync pulse.
   localparam int LCD_H_START = LCD_H_SYNC + LCD_H_BACK;
   localparam int LCD_V_START = LCD_V_SYNC + LCD_V_BACK;

   localparam rgb_t WHITE = 24'hFF_FFFF;
   localparam rgb_t BLACK = 24'h00_0000;

endpackage

// File: rtl/lcd_timing_driver_if.sv
// Purpose : pixel request bus (to the overlay) plus the RGB panel pins, bundled.
// Latency : n/a (wires only).
// Backpressure: none; the panel is a free-running stream and the overlay must keep up.
// Ports   : master = timing driver (drives coords/request/panel pins, takes pixel_data);
//           slave  = pixel producer + panel side.
interface lcd_timing_driver_if;
   import lcd_timing_pkg::*;

   coord_t pixel_xpos;
   coord_t pixel_ypos;
   logic   data_req;
   rgb_t   pixel_data;
   logic   lcd_hs;
   logic   lcd_vs;
   logic   lcd_de;
   rgb_t   lcd_rgb;
   logic   lcd_bl;
   logic   frame_done;

   modport master (
      output pixel_xpos, pixel_ypos, data_req,
      output lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, frame_done,
      input  pixel_data
   );

   modport slave (
      input  pixel_xpos, pixel_ypos, data_req,
      input  lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, frame_done,
      output pixel_data
   );

endinterface

// File: rtl/lcd_sync_cnt.sv
// Purpose : free-running horizontal/vertical position counters for one video frame.
// Latency : counters advance every lcd_pclk; line_end is combinational from h_cnt.
// Backpressure: none; counts unconditionally.
// Ports   : lcd_pclk, sys_rst_n (async, active low); h_cnt, v_cnt, line_end out.
module lcd_sync_cnt
   import lcd_timing_pkg::*;
#(
   parameter int H_TOTAL = LCD_H_TOTAL,
   parameter int V_TOTAL = LCD_V_TOTAL
) (
   input  logic   lcd_pclk,
   input  logic   sys_rst_n,
   output coord_t h_cnt,
   output coord_t v_cnt,
   output logic   line_end
);

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

   assign line_end = (h_cnt == H_LAST);

   // v_cnt only moves on the h_cnt wrap, so frame wrap and line wrap share one edge.
   always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
         h_cnt <= h_cnt + coord_t'(1);
      end
   end

endmodule

// File: rtl/lcd_timing_driver.sv
// Purpose : RGB panel timing generator; issues pixel coordinates and drives sync/DE/RGB pins.
// Latency : coordinates lead lcd_de by 1 pclk so a registered producer lands on the active pixel.
// Backpressure: none; producer must return pixel_data exactly one lcd_pclk after a request.
// Ports   : lcd_pclk, sys_rst_n (async, active low); lcd = master side of lcd_timing_driver_if.
module lcd_timing_driver
   import lcd_timing_pkg::*;
#(
   parameter int H_SYNC  = LCD_H_SYNC,
   parameter int H_BACK  = LCD_H_BACK,
   parameter int H_DISP  = LCD_H_DISP,
   parameter int H_TOTAL = LCD_H_TOTAL,
   parameter int V_SYNC  = LCD_V_SYNC,
   parameter int V_BACK  = LCD_V_BACK,
   parameter int V_DISP  = LCD_V_DISP,
   parameter int V_TOTAL = LCD_V_TOTAL
) (
   input  logic                lcd_pclk,
   input  logic                sys_rst_n,
   lcd_timing_driver_if.master lcd
);

   // Request window opens one column before the first active pixel so that
   // the producer's register stage absorbs the lead.
   localparam coord_t H_REQ_FIRST = coord_t'(H_SYNC + H_BACK - 1);
   localparam coord_t H_REQ_END   = coord_t'(H_SYNC + H_BACK + H_DISP - 1);
   localparam coord_t V_ACT_FIRST = coord_t'(V_SYNC + V_BACK);
   localparam coord_t V_ACT_END   = coord_t'(V_SYNC + V_BACK + V_DISP);
   localparam coord_t H_SYNC_END  = coord_t'(H_SYNC);
   localparam coord_t V_SYNC_END  = coord_t'(V_SYNC);
   localparam coord_t V_LAST      = coord_t'(V_TOTAL - 1);

   coord_t h_cnt;
   coord_t v_cnt;
   logic   line_end;
   logic   data_req;

   logic   de_q;
   logic   hs_q;
   logic   vs_q;
   logic   bl_q;
   logic   frame_done_q;

   lcd_sync_cnt #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_sync_cnt (
      .lcd_pclk  (lcd_pclk),
      .sys_rst_n (sys_rst_n),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .line_end  (line_end)
   );

   assign data_req = (h_cnt >= H_REQ_FIRST) && (h_cnt < H_REQ_END) &&
                     (v_cnt >= V_ACT_FIRST) && (v_cnt < V_ACT_END);

   // Subtractions are only exposed inside the window, so they never underflow.
   assign lcd.data_req   = data_req;
   assign lcd.pixel_xpos = data_req ? (h_cnt - H_REQ_FIRST) : '0;
   assign lcd.pixel_ypos = data_req ? (v_cnt - V_ACT_FIRST) : '0;

   // Sync, DE and frame strobe all come from the same register stage so they
   // stay mutually aligned one pclk behind the counters.
   always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         de_q         <= 1'b0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         bl_q         <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         de_q         <= data_req;
         hs_q         <= (h_cnt >= H_SYNC_END);
         vs_q         <= (v_cnt >= V_SYNC_END);
         bl_q         <= 1'b1;
         frame_done_q <= line_end && (v_cnt == V_LAST);
      end
   end

   assign lcd.lcd_de     = de_q;
   assign lcd.lcd_hs     = hs_q;
   assign lcd.lcd_vs     = vs_q;
   assign lcd.lcd_bl     = bl_q;
   assign lcd.frame_done = frame_done_q;

   // Blanking is forced black whatever the overlay happens to be driving.
   assign lcd.lcd_rgb = de_q ? lcd.pixel_data : BLACK;

endmodule
